// File: rtl/data_sync_ctrl.sv
// Enable-qualified bus synchronizer: the single-bit BUS_ENABLE is synchronized and
// edge-detected, then the quasi-static UNSYNC_BUS is captured once per accepted event.
module data_sync_ctrl #(
  parameter int NUM_STAGES = 2,  // 2..8
  parameter int BUS_WIDTH  = 8,  // 1..64
  parameter int EN_MODE    = 0,  // 0: rising edge is an event, 1: any edge is an event
  parameter int MIN_GAP    = 4   // 1..255 hold-off cycles after each capture
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
  input  logic                 BUS_ENABLE,
  input  logic                 CLR_OVR,
  output logic [BUS_WIDTH-1:0] SYNC_BUS,
  output logic                 ENABLE_PULSE,
  output logic                 BUSY,
  output logic                 OVERRUN,
  output logic [7:0]           EVENT_CNT,
  output logic [0:0]           DBG_STATE
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;
  localparam logic [7:0] GAP_LOAD = 8'(MIN_GAP - 1);

  logic [NUM_STAGES-1:0] en_chain;
  logic                  en_s;
  logic                  en_q;
  logic                  evt;
  logic                  evt_r;
  logic [0:0]            state;
  logic [0:0]            state_nxt;
  logic [7:0]            gap_cnt;
  logic                  accept;
  logic                  drop;

  // Only the qualifier crosses domains; the bus is sampled once it is known stable.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      en_chain <= '0;
      en_q     <= 1'b0;
      evt_r    <= 1'b0;
    end else begin
      en_chain <= {en_chain[NUM_STAGES-2:0], BUS_ENABLE};
      en_q     <= en_s;
      evt_r    <= evt;
    end
  end

  assign en_s = en_chain[NUM_STAGES-1];
  assign evt  = (EN_MODE != 0) ? (en_s ^ en_q) : (en_s & ~en_q);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (evt_r) state_nxt = ST_HOLD;
      ST_HOLD: if (gap_cnt == 8'd0) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign accept = (state == ST_IDLE) && evt_r;
  assign drop   = (state == ST_HOLD) && evt_r;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ENABLE_PULSE is a one-cycle strobe with no back-pressure: SYNC_BUS is valid and
  // new in exactly the cycle ENABLE_PULSE is high, and events seen while BUSY are lost.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      SYNC_BUS     <= '0;
      ENABLE_PULSE <= 1'b0;
      gap_cnt      <= 8'd0;
      EVENT_CNT    <= 8'd0;
    end else begin
      ENABLE_PULSE <= accept;
      if (accept) begin
        SYNC_BUS  <= UNSYNC_BUS;
        gap_cnt   <= GAP_LOAD;
        EVENT_CNT <= EVENT_CNT + 8'd1;
      end else if ((state == ST_HOLD) && (gap_cnt != 8'd0)) begin
        gap_cnt <= gap_cnt - 8'd1;
      end
    end
  end

  // A dropped event outranks a simultaneous clear so no overrun goes unreported.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      OVERRUN <= 1'b0;
    end else if (drop) begin
      OVERRUN <= 1'b1;
    end else if (CLR_OVR) begin
      OVERRUN <= 1'b0;
    end
  end

  assign BUSY      = (state == ST_HOLD);
  assign DBG_STATE = state;

endmodule
